// File: rtl/vend_controller_if.sv
// vend_controller_if: coin/select request inputs and vend/change/status outputs of the vending controller.
interface vend_controller_if;
  logic dollar, quarter, dime, nickel, select_valid, cancel;
  logic [1:0] select, item_out;
  logic [8:0] balance;
  logic vend, insufficient, coin_return, change_q, change_d, change_n, busy;
  modport master(
    output dollar, quarter, dime, nickel, select_valid, select, cancel,
    input balance, vend, item_out, insufficient, coin_return, change_q, change_d, change_n, busy
  );
  modport slave(
    input dollar, quarter, dime, nickel, select_valid, select, cancel,
    output balance, vend, item_out, insufficient, coin_return, change_q, change_d, change_n, busy
  );
endinterface

// File: rtl/vend_controller.sv
// vend_controller: coin-credit vending FSM with largest-first change; VEND_AUTO_CHANGE_EN refunds leftover credit after each vend.
module vend_controller #(
  parameter logic [8:0] PRICE0 = 9'd100,
  parameter logic [8:0] PRICE1 = 9'd125,
  parameter logic [8:0] PRICE2 = 9'd150,
  parameter logic [8:0] PRICE3 = 9'd75,
  parameter logic [8:0] MAX_BALANCE = 9'd500
) (
  input logic clk,
  input logic reset,
  vend_controller_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, VEND = 2'd2, CHANGE = 2'd3;
  logic [1:0] state, state_n, post_vend;
  logic [8:0] sum, credit, price, give, bal_n;
  logic open, over, accept, sel, afford, vend_n;
  always_comb begin
    sum = (bus.dollar ? 9'd100 : 9'd0) + (bus.quarter ? 9'd25 : 9'd0) + (bus.dime ? 9'd10 : 9'd0) + (bus.nickel ? 9'd5 : 9'd0);
    open = state == IDLE || state == COLLECT;
    over = {1'b0, bus.balance} + {1'b0, sum} > {1'b0, MAX_BALANCE};
    accept = open && sum != 9'd0 && !over;
    credit = accept ? bus.balance + sum : bus.balance;
    price = bus.select == 2'd0 ? PRICE0 : bus.select == 2'd1 ? PRICE1 : bus.select == 2'd2 ? PRICE2 : PRICE3;
    afford = bus.balance >= price;
    sel = state == COLLECT && !bus.cancel && bus.select_valid;
    vend_n = sel && afford;
    give = state != CHANGE ? 9'd0 : bus.balance >= 9'd25 ? 9'd25 : bus.balance >= 9'd10 ? 9'd10 : bus.balance >= 9'd5 ? 9'd5 : 9'd0;
    bal_n = state == CHANGE ? bus.balance - give : vend_n ? credit - price : credit;
    state_n = state == IDLE ? (accept ? COLLECT : IDLE)
            : state == COLLECT ? (bus.cancel ? CHANGE : vend_n ? VEND : COLLECT)
            : state == VEND ? post_vend
            : (bus.balance == 9'd0 ? IDLE : CHANGE);
  end
`ifdef VEND_AUTO_CHANGE_EN
  assign post_vend = CHANGE;
`else
  assign post_vend = bus.balance != 9'd0 ? COLLECT : IDLE;
`endif
  assign bus.busy = state == VEND || state == CHANGE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      bus.balance <= 9'd0;
      bus.vend <= 1'b0;
      bus.item_out <= 2'd0;
      bus.insufficient <= 1'b0;
      bus.coin_return <= 1'b0;
      bus.change_q <= 1'b0;
      bus.change_d <= 1'b0;
      bus.change_n <= 1'b0;
    end else begin
      state <= state_n;
      bus.balance <= bal_n;
      bus.vend <= vend_n;
      if (vend_n) bus.item_out <= bus.select;
      bus.insufficient <= sel && !afford;
      bus.coin_return <= sum != 9'd0 && !accept;
      bus.change_q <= give == 9'd25;
      bus.change_d <= give == 9'd10;
      bus.change_n <= give == 9'd5;
    end
endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: random and directed stimulus against a credit-ledger model of the vending controller.
module tb_vend_controller;
  localparam int MAXB = 500;
  localparam int M_IDLE = 0, M_COLLECT = 1, M_VEND = 2, M_REFUND = 3;
  int prices[4] = '{100, 125, 150, 75};
  logic clk = 1'b0;
  logic reset;
  int total = 0, bad = 0;
  vend_controller_if bus();
  vend_controller dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int largest(int b);
    int denoms[3] = '{25, 10, 5};
    foreach (denoms[i]) if (b >= denoms[i]) return denoms[i];
    return 0;
  endfunction

  int m_mode = 0, m_bal = 0, m_item = 0;
  bit m_vend = 0, m_ins = 0, m_cr = 0, m_q = 0, m_d = 0, m_n = 0;
  int coin, pool, give, price;
  bit okcoin;
  always_comb begin
    coin = 100 * int'(bus.dollar) + 25 * int'(bus.quarter) + 10 * int'(bus.dime) + 5 * int'(bus.nickel);
    okcoin = m_mode < M_VEND && coin > 0 && m_bal + coin <= MAXB;
    pool = m_bal + (okcoin ? coin : 0);
    give = m_mode == M_REFUND ? largest(m_bal) : 0;
    price = prices[bus.select];
  end

  always @(posedge clk or posedge reset)
    if (reset) begin
      m_mode <= M_IDLE; m_bal <= 0; m_item <= 0;
      m_vend <= 0; m_ins <= 0; m_cr <= 0; m_q <= 0; m_d <= 0; m_n <= 0;
    end else begin
      m_cr <= coin > 0 && !okcoin;
      m_vend <= 0;
      m_ins <= 0;
      m_q <= give == 25;
      m_d <= give == 10;
      m_n <= give == 5;
      case (m_mode)
        M_IDLE: begin
          m_bal <= pool;
          if (okcoin) m_mode <= M_COLLECT;
        end
        M_COLLECT:
          if (bus.cancel) begin
            m_bal <= pool;
            m_mode <= M_REFUND;
          end else if (bus.select_valid && m_bal >= price) begin
            m_bal <= pool - price;
            m_vend <= 1;
            m_item <= int'(bus.select);
            m_mode <= M_VEND;
          end else begin
            m_bal <= pool;
            m_ins <= bus.select_valid;
          end
`ifdef VEND_AUTO_CHANGE_EN
        M_VEND: m_mode <= M_REFUND;
`else
        M_VEND: m_mode <= m_bal > 0 ? M_COLLECT : M_IDLE;
`endif
        default: begin
          m_bal <= m_bal - give;
          if (m_bal == 0) m_mode <= M_IDLE;
        end
      endcase
    end

  always @(negedge clk) begin
    chk("balance", int'(bus.balance), m_bal);
    chk("vend", int'(bus.vend), int'(m_vend));
    if (m_vend) chk("item_out", int'(bus.item_out), m_item);
    chk("insufficient", int'(bus.insufficient), int'(m_ins));
    chk("coin_return", int'(bus.coin_return), int'(m_cr));
    chk("change_q", int'(bus.change_q), int'(m_q));
    chk("change_d", int'(bus.change_d), int'(m_d));
    chk("change_n", int'(bus.change_n), int'(m_n));
    chk("busy", int'(bus.busy), int'(m_mode >= M_VEND));
    chk("bal_mult5", int'(bus.balance) % 5, 0);
    chk("bal_max", int'(int'(bus.balance) <= MAXB), 1);
  end

  task automatic drive(bit d, bit q, bit di, bit n, bit sv, bit [1:0] s, bit c);
    bus.dollar = d; bus.quarter = q; bus.dime = di; bus.nickel = n;
    bus.select_valid = sv; bus.select = s; bus.cancel = c;
    @(posedge clk);
    #2;
    bus.dollar = 0; bus.quarter = 0; bus.dime = 0; bus.nickel = 0;
    bus.select_valid = 0; bus.select = 0; bus.cancel = 0;
  endtask

  task automatic idle(int k);
    repeat (k) drive(0, 0, 0, 0, 0, 2'd0, 0);
  endtask

  initial begin
    bus.dollar = 0; bus.quarter = 0; bus.dime = 0; bus.nickel = 0;
    bus.select_valid = 0; bus.select = 0; bus.cancel = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_balance", int'(bus.balance), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_item", int'(bus.item_out), 0);
    chk("rst_vend", int'(bus.vend), 0);
    reset = 0;
    drive(1, 1, 0, 0, 0, 2'd0, 0);
    chk("dq_balance", int'(bus.balance), 125);
    chk("dq_busy", int'(bus.busy), 0);
    drive(0, 0, 0, 0, 1, 2'd1, 0);
    chk("s1_vend", int'(bus.vend), 1);
    chk("s1_item", int'(bus.item_out), 1);
    chk("s1_balance", int'(bus.balance), 0);
    idle(3);
    drive(1, 1, 0, 0, 0, 2'd0, 0);
    drive(0, 1, 0, 0, 0, 2'd0, 0);
    chk("p150_balance", int'(bus.balance), 150);
    drive(0, 0, 0, 0, 1, 2'd3, 0);
    chk("s3_vend", int'(bus.vend), 1);
    chk("s3_balance", int'(bus.balance), 75);
    idle(1);
`ifdef VEND_AUTO_CHANGE_EN
    chk("s3_refund_busy", int'(bus.busy), 1);
    idle(1);
    chk("s3_first_q", int'(bus.change_q), 1);
    chk("s3_after_q", int'(bus.balance), 50);
    idle(4);
`else
    chk("s3_keep_balance", int'(bus.balance), 75);
    chk("s3_collect_busy", int'(bus.busy), 0);
    drive(0, 0, 0, 0, 0, 2'd0, 1);
    idle(5);
`endif
    drive(0, 1, 0, 0, 0, 2'd0, 0);
    drive(0, 1, 0, 0, 0, 2'd0, 0);
    drive(0, 0, 0, 0, 1, 2'd0, 0);
    chk("s0_insufficient", int'(bus.insufficient), 1);
    chk("s0_balance", int'(bus.balance), 50);
    drive(0, 0, 0, 0, 0, 2'd0, 1);
    chk("c50_busy", int'(bus.busy), 1);
    idle(1);
    chk("c50_q1", int'(bus.change_q), 1);
    chk("c50_bal1", int'(bus.balance), 25);
    idle(1);
    chk("c50_q2", int'(bus.change_q), 1);
    chk("c50_bal2", int'(bus.balance), 0);
    idle(1);
    chk("c50_idle", int'(bus.busy), 0);
    repeat (4) drive(1, 0, 0, 0, 0, 2'd0, 0);
    repeat (2) drive(0, 1, 0, 0, 0, 2'd0, 0);
    chk("b450_balance", int'(bus.balance), 450);
    drive(1, 0, 0, 0, 0, 2'd0, 0);
    chk("b450_return", int'(bus.coin_return), 1);
    chk("b450_held", int'(bus.balance), 450);
    drive(0, 0, 0, 0, 0, 2'd0, 1);
    drive(0, 0, 0, 1, 0, 2'd0, 0);
    chk("chg_coin_return", int'(bus.coin_return), 1);
    chk("chg_q", int'(bus.change_q), 1);
    chk("chg_balance", int'(bus.balance), 425);
    idle(20);
    drive(0, 1, 1, 1, 0, 2'd0, 0);
    chk("b40_balance", int'(bus.balance), 40);
    drive(0, 0, 0, 0, 0, 2'd0, 1);
    idle(1);
    chk("b40_q", int'(bus.change_q), 1);
    chk("b40_bal", int'(bus.balance), 15);
    reset = 1;
    #1;
    chk("abort_balance", int'(bus.balance), 0);
    chk("abort_q", int'(bus.change_q), 0);
    chk("abort_busy", int'(bus.busy), 0);
    @(posedge clk);
    #2;
    reset = 0;
    idle(3);
    chk("abort_no_d", int'(bus.change_d), 0);
    chk("abort_no_n", int'(bus.change_n), 0);
    chk("abort_idle", int'(bus.busy), 0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(399) == 0) begin
        reset = 1;
        @(posedge clk);
        #2;
        reset = 0;
      end else
        drive($urandom_range(5) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
              $urandom_range(3) == 0, 2'($urandom_range(3)), $urandom_range(15) == 0);
    end
    idle(40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 SHALL have parameter PRICE0, default 9'd100, meaning price of item 0 in cents.
REQ-002 SHALL have parameter PRICE1, default 9'd125, meaning price of item 1.
REQ-003 SHALL have parameter PRICE2, default 9'd150, meaning price of item 2.
REQ-004 SHALL have parameter PRICE3, default 9'd75, meaning price of item 3.
REQ-005 SHALL have parameter MAX_BALANCE, default 9'd500, meaning the credit ceiling.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have ports dollar, quarter, dime, nickel, input, 1 bit each: coin-accepted pulses, one cycle each, any combination per cycle.
REQ-009 SHALL have port select_valid, input, 1 bit: item request strobe.
REQ-010 SHALL have port select, input, 2 bits: item index, sampled only when select_valid=1.
REQ-011 SHALL have port cancel, input, 1 bit: refund request.
REQ-012 SHALL have port balance, output, 9 bits: registered current credit in cents.
REQ-013 SHALL have ports vend and item_out, output, 1 and 2 bits: vend is a one-cycle pulse, item_out is the vended index, valid while vend=1.
REQ-014 SHALL have port insufficient, output, 1 bit: one-cycle pulse, select refused for lack of credit.
REQ-015 SHALL have port coin_return, output, 1 bit: one-cycle pulse, that cycle's coins were rejected.
REQ-016 SHALL have ports change_q, change_d, change_n, output, 1 bit each: one-cycle pulses, dispense one quarter/dime/nickel.
REQ-017 SHALL have port busy, output, 1 bit: high in VEND and CHANGE states.

Function
REQ-018 SHALL implement FSM states IDLE, COLLECT, VEND, CHANGE.
REQ-019 SHALL compute coin sum = 100·dollar + 25·quarter + 10·dime + 5·nickel (max 140) at 9-bit width.
REQ-020 In IDLE/COLLECT, a nonzero coin sum SHALL be credited on the next edge (balance+sum), moving IDLE to COLLECT.
REQ-021 If balance+sum > MAX_BALANCE, all coins of that cycle SHALL be rejected: balance unchanged, coin_return=1 next cycle.
REQ-022 In COLLECT, cancel=1 SHALL move to CHANGE (cancel has priority over select_valid); coins in the same cycle are still credited before refund.
REQ-023 In COLLECT, select_valid with registered balance >= PRICE[select] SHALL move to VEND; else insufficient=1 next cycle, state held.
REQ-024 Select SHALL be compared against the pre-coin registered balance; coins in the same cycle are credited and the price deducted from balance+sum.
REQ-025 VEND SHALL last exactly one cycle with vend=1, item_out=latched select; entry happens one cycle after select_valid.
REQ-026 In VEND and CHANGE, any coin SHALL be rejected with coin_return=1 next cycle.
REQ-027 CHANGE SHALL dispense one coin per cycle, largest first: balance>=25 -> change_q, subtract 25; else >=10 -> change_d; else >=5 -> change_n; balance=0 -> IDLE without pulse.
REQ-028 Balance SHALL always be a multiple of 5 and never exceed MAX_BALANCE; exit from CHANGE leaves balance=0.

Reset
REQ-029 While reset=1, state SHALL be IDLE, balance=0, all pulse outputs and busy=0, item_out=0, independent of clk.
REQ-030 Reset mid-VEND or mid-CHANGE SHALL abort immediately with credit discarded, no further pulses.

Configuration
REQ-031 With macro VEND_AUTO_CHANGE_EN defined, VEND SHALL go to CHANGE and refund remaining credit.
REQ-032 Without VEND_AUTO_CHANGE_EN, VEND SHALL go to COLLECT if remaining balance>0, else IDLE; credit is kept for further purchases.

Verification
REQ-033 Reset, dollar+quarter in one cycle -> balance=125 next cycle, state COLLECT.
REQ-034 Balance 125, select=1 -> vend=1, item_out=1, balance=0, then IDLE, no change pulses.
REQ-035 Balance 150, select=3 with AUTO_CHANGE -> vend, then change_q×3, balance 0, IDLE; without AUTO_CHANGE -> balance 75, COLLECT.
REQ-036 Balance 50, select=0 -> insufficient=1, balance 50; cancel -> change_q×2 then IDLE.
REQ-037 Balance 450, dollar -> coin_return=1, balance 450; coin during CHANGE -> coin_return=1, refund unaffected.
REQ-038 Balance 40 cancelled, reset asserted after first change_q -> balance 0, no change_d/change_n pulses, IDLE.
